// File: rtl/vector_packer_pkg.sv
// Shared types and default sizes for the vector packer and its output stage.
package vector_packer_pkg;

  localparam int WIDTH_VECTOR_DEF = 16;
  localparam int N_DEF            = 16;
  localparam int CNT_W_DEF        = 16;

  // Packer sequencing: FILL accepts samples, STALL waits for the hold register.
  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } packer_state_t;

  // Vector word at the default sizes; lane k occupies bits [k*N +: N].
  typedef logic [WIDTH_VECTOR_DEF-1:0][N_DEF-1:0] vector_t;

  // Lane index width; never narrower than one bit.
  function automatic int idx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/vector_packer_if.sv
// Scalar sample stream into the packer: valid/ready handshake plus framing.
interface vector_packer_if
  import vector_packer_pkg::*;
#(
  parameter int N = N_DEF
) ();

  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_data;
  logic         s_last;
  logic         flush;

  // Sample source side.
  modport master (
    output s_valid,
    output s_data,
    output s_last,
    output flush,
    input  s_ready
  );

  // Packer side.
  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    input  flush,
    output s_ready
  );

endinterface

// File: rtl/vector_packer_out_stage.sv
// Output stage: one-word hold register in front of the FIFO write port,
// write strobe generation and the emitted-vector counter.
module vector_packer_out_stage
  import vector_packer_pkg::*;
#(
  parameter int WIDTH_VECTOR = WIDTH_VECTOR_DEF,
  parameter int N            = N_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         load_i,
  input  logic [WIDTH_VECTOR-1:0][N-1:0] load_data_i,
  input  logic                         fifo_full_i,
  output logic                         hold_free_o,
  output logic                         hold_valid_o,
  output logic                         fifo_winc_o,
  output logic [WIDTH_VECTOR-1:0][N-1:0] fifo_wdata_o,
  output logic [CNT_W-1:0]             vec_cnt_o
);

  logic [WIDTH_VECTOR-1:0][N-1:0] hold_q;
  logic                           hold_valid_q;
  logic [CNT_W-1:0]               cnt_q;

  // The write strobe is combinational on fifo_full so a word leaves in the
  // same cycle the FIFO has room; a draining hold can be refilled on that edge.
  assign fifo_winc_o  = hold_valid_q && !fifo_full_i;
  assign hold_free_o  = !hold_valid_q || fifo_winc_o;
  assign hold_valid_o = hold_valid_q;
  assign fifo_wdata_o = hold_q;
  assign vec_cnt_o    = cnt_q;

  // Hold register: a reload wins over the drain on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (load_i) begin
      hold_q       <= load_data_i;
      hold_valid_q <= 1'b1;
    end else if (fifo_winc_o) begin
      hold_valid_q <= 1'b0;
    end
  end

  // Emitted-vector counter, wraps silently.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (fifo_winc_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vector_packer.sv
// Packs a scalar sample stream into WIDTH_VECTOR-lane words for the core's
// vector input FIFO. Sample k of a vector lands in lane k; short vectors
// (s_last or flush) are zero-padded. At most two vectors are pending:
// one in the hold register and one in the assembly register.
module vector_packer
  import vector_packer_pkg::*;
#(
  parameter int WIDTH_VECTOR = WIDTH_VECTOR_DEF,
  parameter int N            = N_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           rstn,
  vector_packer_if.slave                 s_if,
  input  logic                           fifo_full,
  output logic                           fifo_winc,
  output logic [WIDTH_VECTOR-1:0][N-1:0] fifo_wdata,
  output logic [CNT_W-1:0]               vec_cnt,
  output logic                           busy
);

  localparam int IDX_W = idx_width(WIDTH_VECTOR);

  typedef logic [WIDTH_VECTOR-1:0][N-1:0] vec_t;

  packer_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  vec_t             asm_q, asm_d;
  vec_t             asm_with;
  vec_t             load_data;
  logic             accept;
  logic             last_lane;
  logic             complete;
  logic             load;
  logic             hold_free;
  logic             hold_valid;

  // Accept qualification, completion detection and the assembly image that
  // includes the sample being accepted this cycle.
  always_comb begin
    accept    = s_if.s_valid && (state_q == FILL);
    last_lane = (idx_q == IDX_W'(WIDTH_VECTOR - 1));
    complete  = (accept && (last_lane || s_if.s_last)) ||
                ((state_q == FILL) && s_if.flush && !accept && (idx_q != '0));
    asm_with  = asm_q;
    if (accept) begin
      asm_with[idx_q] = s_if.s_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stall when a vector completes but the hold is occupied.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (complete && !hold_free) state_d = STALL;
      STALL:   if (hold_free)              state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // FSM outputs: sample ready and the hold-register load request.
  always_comb begin
    s_if.s_ready = (state_q == FILL);
    load         = 1'b0;
    load_data    = asm_with;
    case (state_q)
      FILL: begin
        load      = complete && hold_free;
        load_data = asm_with;
      end
      STALL: begin
        load      = hold_free;
        load_data = asm_q;
      end
      default: begin
        load      = 1'b0;
        load_data = asm_with;
      end
    endcase
  end

  // Assembly datapath next state: cleared when handed to hold, otherwise it
  // keeps accumulating; a completed-but-stalled vector is parked here.
  always_comb begin
    asm_d = asm_q;
    idx_d = idx_q;
    if (load) begin
      asm_d = '0;
      idx_d = '0;
    end else if (accept) begin
      asm_d = asm_with;
      idx_d = complete ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Assembly register and lane index.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      asm_q <= '0;
      idx_q <= '0;
    end else begin
      asm_q <= asm_d;
      idx_q <= idx_d;
    end
  end

  vector_packer_out_stage #(
    .WIDTH_VECTOR (WIDTH_VECTOR),
    .N            (N),
    .CNT_W        (CNT_W)
  ) u_out_stage (
    .clk          (clk),
    .rstn         (rstn),
    .load_i       (load),
    .load_data_i  (load_data),
    .fifo_full_i  (fifo_full),
    .hold_free_o  (hold_free),
    .hold_valid_o (hold_valid),
    .fifo_winc_o  (fifo_winc),
    .fifo_wdata_o (fifo_wdata),
    .vec_cnt_o    (vec_cnt)
  );

  assign busy = (idx_q != '0) || (state_q == STALL) || hold_valid;

endmodule

// File: tb/tb_vector_packer.sv
// Self-checking bench for vector_packer at 4 lanes x 8 bits, 4-bit counter.
module tb_vector_packer;

  localparam int WV = 4;
  localparam int NB = 8;
  localparam int CW = 4;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   fifo_full = 1'b0;
  logic                   fifo_winc;
  logic [WV-1:0][NB-1:0]  fifo_wdata;
  logic [CW-1:0]          vec_cnt;
  logic                   busy;

  vector_packer_if #(.N(NB)) sif ();

  vector_packer #(
    .WIDTH_VECTOR (WV),
    .N            (NB),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_if       (sif.slave),
    .fifo_full  (fifo_full),
    .fifo_winc  (fifo_winc),
    .fifo_wdata (fifo_wdata),
    .vec_cnt    (vec_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  src = 8'h01;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        last;
    logic        fl;
    logic        push;
    logic [31:0] word;
    logic        winc;
    logic [3:0]  cnt;
  } row_t;

  row_t tbl[25];

  function automatic row_t mk(input logic v, input logic [7:0] d, input logic last,
                              input logic fl, input logic push, input logic [31:0] word,
                              input logic winc, input logic [3:0] cnt);
    row_t r;
    r.v = v; r.d = d; r.last = last; r.fl = fl;
    r.push = push; r.word = word; r.winc = winc; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any word written to the FIFO.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (rstn === 1'b1 && fifo_winc === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL winc_unexpected actual=%h required=no_write", 32'(fifo_wdata));
      end else begin
        e = exp_q.pop_front();
        chk("fifo_word", 32'(fifo_wdata), e);
        $display("txn write word=%h expected=%h vec_cnt=%0d", 32'(fifo_wdata), e, vec_cnt);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic last, input logic fl);
    @(posedge clk);
    #1;
    sif.s_valid = v;
    sif.s_data  = d;
    sif.s_last  = last;
    sif.flush   = fl;
  endtask

  // Stream n samples with s_valid held, building expected words as samples
  // are accepted. fifo_full is held high for the first full_cycles cycles,
  // then either low or toggled every cycle.
  task automatic stream(input int n, input bit toggle, input int full_cycles,
                        input int exp_at_release, input bit rnd);
    int          sent;
    int          k;
    int          cyc;
    int          budget;
    logic [31:0] w;
    logic [7:0]  d;
    sent = 0; k = 0; cyc = 0; w = '0;
    budget = 20 * n + 60;
    while (sent < n && cyc < budget) begin
      @(posedge clk);
      #1;
      if (cyc < full_cycles) fifo_full = 1'b1;
      else if (toggle)       fifo_full = ~fifo_full;
      else                   fifo_full = 1'b0;
      d = rnd ? 8'($urandom) : src;
      sif.s_valid = 1'b1;
      sif.s_data  = d;
      sif.s_last  = 1'b0;
      sif.flush   = 1'b0;
      tick();
      if (full_cycles > 0 && cyc == full_cycles - 1) begin
        chk("accepts_under_full", 32'(sent), 32'(exp_at_release));
        chk("ready_in_stall", 32'(sif.s_ready), 32'd0);
        chk("busy_in_stall", 32'(busy), 32'd1);
      end
      if (sif.s_ready) begin
        w[8*k +: 8] = d;
        k++;
        sent++;
        src = src + 8'd1;
        if (k == WV) begin
          exp_q.push_back(w);
          w = '0;
          k = 0;
        end
      end
      cyc++;
    end
    if (sent < n) begin
      checks++;
      failures++;
      $display("FAIL stream_timeout actual=%0d required=%0d", sent, n);
    end
    @(posedge clk);
    #1;
    sif.s_valid = 1'b0;
    fifo_full   = 1'b0;
  endtask

  // Wait (bounded) until every expected word has been written and the packer is idle.
  task automatic drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || busy) && c < 100) begin
      tick();
      c++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    tick();
    chk("rst_winc", 32'(fifo_winc), 32'd0);
    chk("rst_ready", 32'(sif.s_ready), 32'd1);
    chk("rst_vec_cnt", 32'(vec_cnt), 32'd0);
    chk("rst_wdata", 32'(fifo_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_last  = 1'b0;
    sif.flush   = 1'b0;

    // Full vectors, s_last short vector, flush cases.
    tbl[0]  = mk(1, 8'h01, 0, 0, 0, 32'h0,        0, 4'd0);
    tbl[1]  = mk(1, 8'h02, 0, 0, 0, 32'h0,        0, 4'd0);
    tbl[2]  = mk(1, 8'h03, 0, 0, 0, 32'h0,        0, 4'd0);
    tbl[3]  = mk(1, 8'h04, 0, 0, 1, 32'h04030201, 0, 4'd0);
    tbl[4]  = mk(1, 8'h05, 0, 0, 0, 32'h0,        1, 4'd0);
    tbl[5]  = mk(1, 8'h06, 0, 0, 0, 32'h0,        0, 4'd1);
    tbl[6]  = mk(1, 8'h07, 0, 0, 0, 32'h0,        0, 4'd1);
    tbl[7]  = mk(1, 8'h08, 0, 0, 1, 32'h08070605, 0, 4'd1);
    tbl[8]  = mk(0, 8'h00, 0, 0, 0, 32'h0,        1, 4'd1);
    tbl[9]  = mk(1, 8'hAA, 0, 0, 0, 32'h0,        0, 4'd2);
    tbl[10] = mk(1, 8'hBB, 1, 0, 1, 32'h0000BBAA, 0, 4'd2);
    tbl[11] = mk(1, 8'h11, 0, 0, 0, 32'h0,        1, 4'd2);
    tbl[12] = mk(1, 8'h22, 0, 0, 0, 32'h0,        0, 4'd3);
    tbl[13] = mk(1, 8'h33, 0, 0, 0, 32'h0,        0, 4'd3);
    tbl[14] = mk(1, 8'h44, 0, 0, 1, 32'h44332211, 0, 4'd3);
    tbl[15] = mk(1, 8'h31, 0, 0, 0, 32'h0,        1, 4'd3);
    tbl[16] = mk(1, 8'h32, 0, 0, 0, 32'h0,        0, 4'd4);
    tbl[17] = mk(1, 8'h33, 0, 0, 0, 32'h0,        0, 4'd4);
    tbl[18] = mk(0, 8'h00, 0, 1, 1, 32'h00333231, 0, 4'd4);
    tbl[19] = mk(0, 8'h00, 0, 0, 0, 32'h0,        1, 4'd4);
    tbl[20] = mk(0, 8'h00, 0, 1, 0, 32'h0,        0, 4'd5);
    tbl[21] = mk(0, 8'h00, 0, 0, 0, 32'h0,        0, 4'd5);
    tbl[22] = mk(1, 8'h41, 1, 1, 1, 32'h00000041, 0, 4'd5);
    tbl[23] = mk(0, 8'h00, 0, 0, 0, 32'h0,        1, 4'd5);
    tbl[24] = mk(0, 8'h00, 0, 0, 0, 32'h0,        0, 4'd6);

    // Reset state.
    tick();
    tick();
    chk("reset_ready", 32'(sif.s_ready), 32'd1);
    chk("reset_winc", 32'(fifo_winc), 32'd0);
    chk("reset_wdata", 32'(fifo_wdata), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_vec_cnt", 32'(vec_cnt), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].last, tbl[i].fl);
      tick();
      $display("txn row=%0d valid=%0d data=%h last=%0d flush=%0d ready=%0d winc=%0d vec_cnt=%0d",
               i, tbl[i].v, tbl[i].d, tbl[i].last, tbl[i].fl, sif.s_ready, fifo_winc, vec_cnt);
      chk($sformatf("row%0d_ready", i), 32'(sif.s_ready), 32'd1);
      chk($sformatf("row%0d_winc", i), 32'(fifo_winc), 32'(tbl[i].winc));
      chk($sformatf("row%0d_vec_cnt", i), 32'(vec_cnt), 32'(tbl[i].cnt));
      if (tbl[i].push) exp_q.push_back(tbl[i].word);
    end
    chk("table_end_busy", 32'(busy), 32'd0);
    chk("table_end_queue", 32'(exp_q.size()), 32'd0);

    // Backpressure: hold fills, then assembly, then STALL with 8 accepted.
    src = 8'h01;
    stream(12, 1'b0, 20, 8, 1'b0);
    drain();
    chk("full_vec_cnt", 32'(vec_cnt), 32'd9);

    // Reset with a vector pending in hold and a partial vector in assembly.
    src = 8'hE1;
    fifo_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, src, 1'b0, 1'b0);
      src = src + 8'd1;
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    pulse_reset();
    src = 8'h51;
    stream(4, 1'b0, 0, 0, 1'b0);
    drain();
    chk("post_reset_vec_cnt", 32'(vec_cnt), 32'd1);

    // Counter wrap after 17 vectors, then 17 more under alternating fifo_full.
    pulse_reset();
    stream(17 * WV, 1'b0, 0, 0, 1'b1);
    drain();
    chk("wrap_vec_cnt", 32'(vec_cnt), 32'd1);
    stream(17 * WV, 1'b1, 0, 0, 1'b1);
    drain();
    chk("toggle_vec_cnt", 32'(vec_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
